// File: rtl/paddle_input.sv
// Paddle input conditioner: synchronizes and debounces up/down/serve buttons,
// resolves up/down conflicts (last pressed wins) and emits a one-cycle serve pulse.
module paddle_input #(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int CNT_W        = 19
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_serve,
  output logic input_up,
  output logic input_down,
  output logic serve_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_t;

  localparam int                 N_BTN       = 3;
  localparam logic [CNT_W-1:0]   LP_CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  // Bit order in all per-button vectors: [0]=up, [1]=down, [2]=serve
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_db;
  logic [N_BTN-1:0] r_db_q;
  logic [CNT_W-1:0] r_cnt [N_BTN];
  logic             r_serve_pulse;
  state_t           r_state;
  state_t           w_state_nxt;

  logic [N_BTN-1:0] w_rise;
  logic             w_up;
  logic             w_down;
  logic             w_rise_up;
  logic             w_rise_down;

  assign w_rise      = r_db & ~r_db_q;
  assign w_up        = r_db[0];
  assign w_down      = r_db[1];
  assign w_rise_up   = w_rise[0];
  assign w_rise_down = w_rise[1];

  // Any sample that matches the current level restarts the stability count
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_db          <= '0;
      r_db_q        <= '0;
      r_serve_pulse <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1       <= {btn_serve, btn_down, btn_up};
      r_sync2       <= r_sync1;
      r_db_q        <= r_db;
      r_serve_pulse <= w_rise[2];
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == LP_CNT_LAST) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fresh press of the opposite direction overrides a held direction
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_up && !w_down) begin
          w_state_nxt = ST_UP;
        end else if (w_down && !w_up) begin
          w_state_nxt = ST_DOWN;
        end
      end
      ST_UP: begin
        if (w_rise_down || (!w_up && w_down)) begin
          w_state_nxt = ST_DOWN;
        end else if (!w_up && !w_down) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DOWN: begin
        if (w_rise_up || (!w_down && w_up)) begin
          w_state_nxt = ST_UP;
        end else if (!w_down && !w_up) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign input_up    = (r_state == ST_UP);
  assign input_down  = (r_state == ST_DOWN);
  assign serve_pulse = r_serve_pulse;

endmodule

// File: tb/tb_paddle_input.sv
// Directed bench for paddle_input with DEBOUNCE_CNT=4: table of held-input
// segments checked every cycle, plus hand-written reset-mid-operation sequence.
module tb_paddle_input;

  localparam int DEBOUNCE_CNT = 4;
  localparam int CNT_W        = 3;

  logic clk       = 1'b0;
  logic clr_n     = 1'b0;
  logic btn_up    = 1'b0;
  logic btn_down  = 1'b0;
  logic btn_serve = 1'b0;
  logic input_up;
  logic input_down;
  logic serve_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  paddle_input #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_serve  (btn_serve),
    .input_up   (input_up),
    .input_down (input_down),
    .serve_pulse(serve_pulse)
  );

  // Hold the inputs for n cycles; after every edge expect {up,down,serve}
  typedef struct {
    logic [2:0] btn;
    int         n;
    logic [2:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] btn, input int n,
                              input logic [2:0] exp, input string name);
    vec_t v;
    v.btn  = btn;
    v.n    = n;
    v.exp  = exp;
    v.name = name;
    return v;
  endfunction

  task automatic check_out(input string name, input logic [2:0] exp);
    logic [2:0] act;
    act = {input_up, input_down, serve_pulse};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got up/down/serve=%b required %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;

    // btn = {up, down, serve}; exp = {input_up, input_down, serve_pulse}
    vecs.push_back(mk(3'b100,  6, 3'b000, "up_press_latency"));
    vecs.push_back(mk(3'b100,  4, 3'b100, "up_held"));
    vecs.push_back(mk(3'b000,  6, 3'b100, "up_release_latency"));
    vecs.push_back(mk(3'b000,  4, 3'b000, "up_released"));

    vecs.push_back(mk(3'b010,  3, 3'b000, "down_glitch3"));
    vecs.push_back(mk(3'b000,  8, 3'b000, "down_glitch3_after"));
    vecs.push_back(mk(3'b010,  3, 3'b000, "down_dropout_pre"));
    vecs.push_back(mk(3'b000,  1, 3'b000, "down_dropout_low"));
    vecs.push_back(mk(3'b010,  6, 3'b000, "down_dropout_recount"));
    vecs.push_back(mk(3'b000,  1, 3'b010, "down_accept"));
    vecs.push_back(mk(3'b000,  5, 3'b010, "down_release_latency"));
    vecs.push_back(mk(3'b000,  4, 3'b000, "down_released"));

    vecs.push_back(mk(3'b100,  6, 3'b000, "lpw_up_latency"));
    vecs.push_back(mk(3'b100,  3, 3'b100, "lpw_up_held"));
    vecs.push_back(mk(3'b110,  6, 3'b100, "lpw_down_latency"));
    vecs.push_back(mk(3'b110,  3, 3'b010, "lpw_down_wins"));
    vecs.push_back(mk(3'b100,  6, 3'b010, "lpw_down_release_latency"));
    vecs.push_back(mk(3'b100,  3, 3'b100, "lpw_back_to_up"));
    vecs.push_back(mk(3'b000,  6, 3'b100, "lpw_up_release_latency"));
    vecs.push_back(mk(3'b000,  4, 3'b000, "lpw_idle"));

    vecs.push_back(mk(3'b110, 10, 3'b000, "simul_press_idle"));
    vecs.push_back(mk(3'b100,  6, 3'b000, "simul_down_release_latency"));
    vecs.push_back(mk(3'b100,  3, 3'b100, "simul_up_after_release"));
    vecs.push_back(mk(3'b000,  6, 3'b100, "simul_up_release_latency"));
    vecs.push_back(mk(3'b000,  4, 3'b000, "simul_idle"));

    vecs.push_back(mk(3'b001,  6, 3'b000, "serve_latency"));
    vecs.push_back(mk(3'b001,  1, 3'b001, "serve_pulse"));
    vecs.push_back(mk(3'b001, 43, 3'b000, "serve_held_no_repeat"));
    vecs.push_back(mk(3'b000, 10, 3'b000, "serve_release_no_pulse"));

    clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_state", 3'b000);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        @(negedge clk);
        {btn_up, btn_down, btn_serve} = vecs[i].btn;
        @(posedge clk);
        #1;
        check_out(vecs[i].name, vecs[i].exp);
      end
    end

    // Reset mid-operation with the up button held through reset release
    @(negedge clk);
    btn_up = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      k++;
      if (input_up) break;
    end
    check_int("rst_pre_up_edges", k, 7);
    check_out("rst_pre_up_level", 3'b100);

    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check_out("rst_async_drop", 3'b000);
    @(posedge clk);
    #1;
    check_out("rst_held_low", 3'b000);

    @(negedge clk);
    clr_n = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      k++;
      if (input_up) break;
    end
    check_int("rst_release_up_edges", k, 7);
    check_out("rst_release_up_level", 3'b100);

    @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_out("final_idle", 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
